pc_sequencer: RTL
=================

// Module: pc_sequencer
// PURPOSE
//  Parametrised program-counter sequencer; next generation of the core's PC block.
//  Adds signed relative branches, absolute jumps, and call/return through a
//  return-address stack (RAS), plus stall and a configurable halt address.
//  Latched fault codes replace the silent trap.
//  Sits between decode (control strobes, offsets/targets) and instruction memory (PC).
// PARAMETERS
//  PC_W       10   PC width in bits.
//  OFF_W       8   width of signed branch offset.
//  RAS_DEPTH   4   return-address stack entries (>=1).
//  RESET_PC    0   PC value loaded by init.
//  HALT_PC    63   halt raised when PC > HALT_PC. Must be < 2**PC_W-1.
// PORTS
//  CLK          in   1      clock; all state updates on posedge.
//  init         in   1      synchronous, active-high reset.
//  stall        in   1      hold PC and stack this cycle.
//  branch_en    in   1      conditional relative branch request.
//  EQUAL        in   1      branch condition; branch taken = branch_en & EQUAL.
//  br_offset    in   OFF_W  signed offset, added to the current PC.
//  jump_en      in   1      absolute jump to target.
//  call_en      in   1      push PC+1, then jump to target.
//  ret_en       in   1      pop RAS into PC.
//  target       in   PC_W   absolute destination for jump_en and call_en.
//  PC           out  PC_W   current fetch address.
//  halt         out  1      sticky halt.
//  fault        out  2      fault_t: 00 NONE, 01 RAS_OVF, 10 RAS_UNF, 11 BR_RANGE.
//  ras_level    out  $clog2(RAS_DEPTH+1)  current number of RAS entries.
// BEHAVIOUR
//  Reset
//  - init=1: PC=RESET_PC, halt=0, fault=NONE, ras_level=0.
//  - init overrides every other input.
//  Per-edge priority (first match wins; lower-priority strobes are dropped)
//  1. halt=1: all state frozen; only init releases it.
//  2. PC > HALT_PC: halt<=1, fault unchanged, PC held.
//  3. stall: PC and RAS held.
//  4. ret_en: ras_level==0 -> halt<=1, fault<=RAS_UNF, PC held.
//     Otherwise PC<=top entry, pop.
//  5. call_en: ras_level==RAS_DEPTH -> halt<=1, fault<=RAS_OVF, PC held.
//     Otherwise push PC+1, PC<=target.
//  6. jump_en: PC<=target.
//  7. branch_en & EQUAL: sum = PC + sext(br_offset), computed at PC_W+1 bits signed.
//     - Sum <0 or >2**PC_W-1 -> halt<=1, fault<=BR_RANGE, PC held. No modular wrap.
//     - Otherwise PC<=sum.
//  8. Default: PC<=PC+1. This includes branch_en with EQUAL=0.
//  Timing and latency
//  - New PC is visible the cycle after the strobe.
//  - halt and fault update in the same edge as the detecting condition.
//  - fault is written once, only while halt=0.
//  Return-address stack
//  - The stack itself is never modified in a faulting cycle.
//  - Simultaneous call_en and ret_en: ret wins, so net behaviour is a pop.
//  - Offset 0 taken: PC unchanged; legal self-loop, caught by no watchdog.
//  - init mid-operation discards the stack contents (ras_level=0).
// STRUCTURE
//  Package pc_seq_pkg:
//  - fault_t enum.
//  - FAULT_* constants.
//  - ras_level width function clog2p1.
//  Sub-module ras_stack:
//  - Parametrised LIFO with push/pop/full/empty/top/level.
//  - Synchronous init clear.
//  - Push and pop never asserted together by the parent.
//  Top level: next-PC priority mux, range check, halt/fault registers.
// TESTING  (PC_W=10, OFF_W=8, RAS_DEPTH=4, HALT_PC=63)
//  1. Sequential run.
//     Stimulus: init, then idle.
//     Expect: PC 0,1,...,64; halt=1 on the edge after PC=64; PC stays 64; fault=00.
//  2. Branches.
//     Stimulus: at PC=10 branch_en=1, EQUAL=1, br_offset=-4.
//     Expect: PC=6. With EQUAL=0: PC=11.
//     Stimulus: at PC=2, offset=-5.
//     Expect: halt=1, fault=11, PC=2.
//  3. Call/return.
//     Stimulus: at PC=5 call_en, target=40; at PC=41 ret_en.
//     Expect: PC=40, ras_level=1; then PC=6, ras_level=0.
//  4. RAS limits.
//     Stimulus: five nested calls.
//     Expect: fifth call gives halt=1, fault=01, ras_level=4.
//     Stimulus: after init, ret_en.
//     Expect: fault=10.
//  5. Stall and priority.
//     Stimulus: stall=1 with jump_en for 3 cycles.
//     Expect: PC frozen.
//     Stimulus: call_en and ret_en together at ras_level=1.
//     Expect: pop; PC=popped value.
//  6. Reset mid-operation.
//     Stimulus: init while halt=1, fault=01, ras_level=4.
//     Expect: next edge PC=0, halt=0, fault=00, ras_level=0.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Package: pc_seq_pkg
// Shared types and helpers for the program-counter sequencer.
//   fault_t   : latched fault code reported by pc_sequencer.
//   clog2p1() : width needed to hold a count from 0 to depth inclusive.
package pc_seq_pkg;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'b00,
      FAULT_RAS_OVF  = 2'b01,
      FAULT_RAS_UNF  = 2'b10,
      FAULT_BR_RANGE = 2'b11
   } fault_t;

   // Width of a counter that must represent 0..depth (a stack level, not an index).
   function automatic int clog2p1(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/pc_sequencer_ras_stack.sv
// Module: ras_stack
// Return-address LIFO used by pc_sequencer for call/return.
// Ports:
//   CLK    in   clock, all updates on posedge
//   init   in   synchronous clear (level to zero, entries zeroed)
//   push   in   write din on top of the stack (ignored when full)
//   pop    in   discard the top entry (ignored when empty)
//   din    in   W-bit value to push
//   top    out  current top entry (zero when empty)
//   level  out  number of valid entries, 0..DEPTH
//   full   out  level == DEPTH
//   empty  out  level == 0
// The parent never raises push and pop in the same cycle; push is given
// precedence here only so the behaviour is defined.
module ras_stack
   import pc_seq_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = 10,
   parameter int LVL_W = 3
) (
   input  logic             CLK,
   input  logic             init,
   input  logic             push,
   input  logic             pop,
   input  logic [W-1:0]     din,
   output logic [W-1:0]     top,
   output logic [LVL_W-1:0] level,
   output logic             full,
   output logic             empty
);

   logic [W-1:0]     mem_r [DEPTH];
   logic [LVL_W-1:0] level_r;
   logic [W-1:0]     top_s;

   assign full  = (level_r == LVL_W'(DEPTH));
   assign empty = (level_r == {LVL_W{1'b0}});
   assign level = level_r;
   assign top   = top_s;

   // Entry storage and level counter; the slot written on push is the one at index level.
   always_ff @(posedge CLK) begin
      if (init) begin
         level_r <= {LVL_W{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= {W{1'b0}};
         end
      end else if (push && !full) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (LVL_W'(i) == level_r) begin
               mem_r[i] <= din;
            end else begin
               mem_r[i] <= mem_r[i];
            end
         end
         level_r <= level_r + LVL_W'(1);
      end else if (pop && !empty) begin
         level_r <= level_r - LVL_W'(1);
      end else begin
         level_r <= level_r;
      end
   end

   // Top-of-stack read mux: entry at index level-1, zero when empty.
   always_comb begin
      top_s = {W{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         top_s = (LVL_W'(i + 1) == level_r) ? mem_r[i] : top_s;
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Module: pc_sequencer
// Program-counter sequencer: sequential fetch, signed relative branches,
// absolute jumps, call/return via a return-address stack, stall, and a
// sticky halt with a latched fault code.
// Ports:
//   CLK        in   clock, all state updates on posedge
//   init       in   synchronous active-high reset, overrides everything
//   stall      in   hold PC and stack this cycle
//   branch_en  in   relative branch request, taken when EQUAL is also high
//   EQUAL      in   branch condition
//   br_offset  in   signed OFF_W-bit offset added to the current PC
//   jump_en    in   absolute jump to target
//   call_en    in   push PC+1 then jump to target
//   ret_en     in   pop the return-address stack into PC
//   target     in   destination for jump_en / call_en
//   PC         out  current fetch address
//   halt       out  sticky halt, cleared only by init
//   fault      out  fault code latched together with halt
//   ras_level  out  number of return addresses held
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int PC_W      = 10,
   parameter int OFF_W     = 8,
   parameter int RAS_DEPTH = 4,
   parameter int RESET_PC  = 0,
   parameter int HALT_PC   = 63
) (
   input  logic                             CLK,
   input  logic                             init,
   input  logic                             stall,
   input  logic                             branch_en,
   input  logic                             EQUAL,
   input  logic [OFF_W-1:0]                 br_offset,
   input  logic                             jump_en,
   input  logic                             call_en,
   input  logic                             ret_en,
   input  logic [PC_W-1:0]                  target,
   output logic [PC_W-1:0]                  PC,
   output logic                             halt,
   output fault_t                           fault,
   output logic [clog2p1(RAS_DEPTH)-1:0]    ras_level
);

   localparam int LVL_W = clog2p1(RAS_DEPTH);
   // Two guard bits: one for the sign, one so that a sum above 2**PC_W-1
   // is still seen as positive and can be flagged instead of wrapping.
   localparam int SW    = PC_W + 2;

   logic [PC_W-1:0] pc_r;
   logic            halt_r;
   fault_t          fault_r;

   logic [PC_W-1:0] pc_nxt_s;
   logic            halt_nxt_s;
   fault_t          fault_nxt_s;
   logic            push_s;
   logic            pop_s;

   logic [PC_W-1:0] ret_addr_s;
   logic [PC_W-1:0] ras_top_s;
   logic            ras_full_s;
   logic            ras_empty_s;

   logic [SW-1:0]   pc_ext_s;
   logic [SW-1:0]   off_ext_s;
   logic [SW-1:0]   sum_s;
   logic            br_bad_s;

   assign ret_addr_s = pc_r + PC_W'(1);

   assign pc_ext_s  = {2'b00, pc_r};
   assign off_ext_s = {{(SW - OFF_W){br_offset[OFF_W-1]}}, br_offset};
   assign sum_s     = pc_ext_s + off_ext_s;
   // Negative (sign bit) or beyond the PC range (bit PC_W set while positive).
   assign br_bad_s  = sum_s[SW-1] | sum_s[PC_W];

   ras_stack #(
      .DEPTH (RAS_DEPTH),
      .W     (PC_W),
      .LVL_W (LVL_W)
   ) u_ras (
      .CLK   (CLK),
      .init  (init),
      .push  (push_s),
      .pop   (pop_s),
      .din   (ret_addr_s),
      .top   (ras_top_s),
      .level (ras_level),
      .full  (ras_full_s),
      .empty (ras_empty_s)
   );

   // Next-PC priority mux with fault detection; the stack is only touched on a non-faulting cycle.
   always_comb begin
      pc_nxt_s    = pc_r;
      halt_nxt_s  = halt_r;
      fault_nxt_s = fault_r;
      push_s      = 1'b0;
      pop_s       = 1'b0;
      if (halt_r) begin
         pc_nxt_s = pc_r;
      end else if (pc_r > PC_W'(HALT_PC)) begin
         halt_nxt_s = 1'b1;
      end else if (stall) begin
         pc_nxt_s = pc_r;
      end else if (ret_en) begin
         if (ras_empty_s) begin
            halt_nxt_s  = 1'b1;
            fault_nxt_s = FAULT_RAS_UNF;
         end else begin
            pc_nxt_s = ras_top_s;
            pop_s    = 1'b1;
         end
      end else if (call_en) begin
         if (ras_full_s) begin
            halt_nxt_s  = 1'b1;
            fault_nxt_s = FAULT_RAS_OVF;
         end else begin
            pc_nxt_s = target;
            push_s   = 1'b1;
         end
      end else if (jump_en) begin
         pc_nxt_s = target;
      end else if (branch_en && EQUAL) begin
         if (br_bad_s) begin
            halt_nxt_s  = 1'b1;
            fault_nxt_s = FAULT_BR_RANGE;
         end else begin
            pc_nxt_s = sum_s[PC_W-1:0];
         end
      end else begin
         pc_nxt_s = ret_addr_s;
      end
   end

   // PC, halt and fault registers with synchronous init.
   always_ff @(posedge CLK) begin
      if (init) begin
         pc_r    <= PC_W'(RESET_PC);
         halt_r  <= 1'b0;
         fault_r <= FAULT_NONE;
      end else begin
         pc_r    <= pc_nxt_s;
         halt_r  <= halt_nxt_s;
         fault_r <= fault_nxt_s;
      end
   end

   assign PC    = pc_r;
   assign halt  = halt_r;
   assign fault = fault_r;

endmodule
